fma16_mul_seq: RTL and testbench

//   Sequential fp16 multiply front-end directly upstream of the fma16 add/round datapath: unpacks x and y, forms

---
 rtl/fma16_pkg.sv | 35 +++
 rtl/fma16_unpack.sv | 31 +++
 rtl/fma16_mul_seq.sv | 149 ++++++++++++++
 tb/tb_fma16_mul_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// fma16 multiply front-end: shared widths, FSM state encoding, unpacked
// operand record and the biased product-exponent helper.
package fma16_pkg;

    localparam int NE   = 5;           // exponent field width
    localparam int NF   = 10;          // fraction field width
    localparam int BIAS = 15;          // exponent bias
    localparam int MW   = NF + 1;      // mantissa width incl. hidden bit
    localparam int PW   = 2 * MW;      // exact mantissa product width
    localparam int EW   = NE + 2;      // signed product exponent width
    localparam int CW   = 4;           // CALC step counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic          sign;
        logic [NE-1:0] exp;    // effective exponent (1 for subnormals)
        logic [MW-1:0] man;    // {hidden, fraction}
        logic          zero;
        logic          inf;
        logic          nan;
        logic          sub;
    } fp16_unpacked_t;

    // ex' + ey' - BIAS as a signed EW-bit value (range -13..45).
    function automatic logic signed [EW-1:0] prod_exp(input logic [NE-1:0] ea,
                                                      input logic [NE-1:0] eb);
        return {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
    endfunction

endpackage

// File: rtl/fma16_unpack.sv
// fma16_unpack: purely combinational fp16 field decode into fp16_unpacked_t.
module fma16_unpack
    import fma16_pkg::*;
(
    input  logic [NE+NF:0]  a_i,
    output fp16_unpacked_t  u_o
);

    logic [NE-1:0] exp_f;
    logic [NF-1:0] frac_f;
    logic          exp_zero;
    logic          exp_ones;

    assign exp_f    = a_i[NE+NF-1:NF];
    assign frac_f   = a_i[NF-1:0];
    assign exp_zero = (exp_f == '0);
    assign exp_ones = (exp_f == '1);

    // Decode sign/exponent/mantissa and classify the operand.
    always_comb begin
        u_o.sign = a_i[NE+NF];
        // Subnormals share the exponent of the smallest normal, without hidden bit.
        u_o.exp  = exp_zero ? NE'(1) : exp_f;
        u_o.man  = {!exp_zero, frac_f};
        u_o.zero = exp_zero && (frac_f == '0);
        u_o.sub  = exp_zero && (frac_f != '0);
        u_o.inf  = exp_ones && (frac_f == '0);
        u_o.nan  = exp_ones && (frac_f != '0);
    end

endmodule

// File: rtl/fma16_mul_seq.sv
// fma16_mul_seq: sequential fp16 multiply front-end. Unpacks x/y, forms sign,
// biased product exponent and the exact 22-bit mantissa product by radix-2
// shift-and-add (one multiplier bit per cycle), and classifies zero/inf/NaN.
// FSM: IDLE -> CALC -> DONE -> IDLE; specials skip CALC.
// Optional build macro FMA16_MUL_EARLY_TERM_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (same pman, variable latency).
module fma16_mul_seq
    import fma16_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           x,
    input  logic [15:0]           y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  psign,
    output logic signed [EW-1:0]  pexp,
    output logic [PW-1:0]         pman,
    output logic                  pzero,
    output logic                  pinf,
    output logic                  pnan
);

    mul_state_t state_q, state_d;

    fp16_unpacked_t ux, uy;

    logic                 accept;
    logic                 special_w, nan_w, inf_w, zero_w;
    logic                 calc_last;

    // Working registers.
    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        mcand_q;
    logic [MW-1:0]        mplier_q;
    logic [PW-1:0]        acc_q;
    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic                 nan_q, inf_q, zero_q;

    // Output registers.
    logic                 out_valid_q;
    logic                 psign_q, pzero_q, pinf_q, pnan_q;
    logic signed [EW-1:0] pexp_q;
    logic [PW-1:0]        pman_q;

    logic                 unused_sub;

    fma16_unpack u_unpack_x (.a_i(x), .u_o(ux));
    fma16_unpack u_unpack_y (.a_i(y), .u_o(uy));

    assign unused_sub = ux.sub ^ uy.sub;

    assign accept    = in_valid && in_ready;
    assign special_w = ux.inf || ux.nan || ux.zero || uy.inf || uy.nan || uy.zero;
    // Priority NaN > inf > zero; inf*0 is NaN.
    assign nan_w     = ux.nan || uy.nan || (ux.inf && uy.zero) || (uy.inf && ux.zero);
    assign inf_w     = !nan_w && (ux.inf || uy.inf);
    assign zero_w    = !nan_w && !inf_w && (ux.zero || uy.zero);

`ifdef FMA16_MUL_EARLY_TERM_EN
    // Done once the bits still to be shifted in after this step are all zero.
    assign calc_last = (mplier_q[MW-1:1] == '0);
`else
    // Fixed MW steps: the step with cnt == MW-1 is the last one.
    assign calc_last = (cnt_q == CW'(MW - 1));
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_d; no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)                   state_d = special_w ? DONE : CALC;
            CALC: if (calc_last)                state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Shift-and-add datapath; working registers are only read in the states that loaded them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (accept) begin
            sign_q   <= ux.sign ^ uy.sign;
            exp_q    <= special_w ? '0 : prod_exp(ux.exp, uy.exp);
            mcand_q  <= {{(PW-MW){1'b0}}, ux.man};
            mplier_q <= uy.man;
            acc_q    <= '0;
            cnt_q    <= '0;
            nan_q    <= nan_w;
            inf_q    <= inf_w;
            zero_q   <= zero_w;
        end else if (state_q == CALC) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Output registers: load on the first DONE cycle, hold until consumed.
    always_ff @(posedge clk) begin
        // NOTE: only the architecturally visible outputs are reset; the datapath above is not.
        if (reset) begin
            out_valid_q <= 1'b0;
            psign_q     <= 1'b0;
            pexp_q      <= '0;
            pman_q      <= '0;
            pzero_q     <= 1'b0;
            pinf_q      <= 1'b0;
            pnan_q      <= 1'b0;
        end else if (state_q == DONE) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                psign_q     <= sign_q;
                pexp_q      <= exp_q;
                pman_q      <= acc_q;
                pzero_q     <= zero_q;
                pinf_q      <= inf_q;
                pnan_q      <= nan_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign psign     = psign_q;
    assign pexp      = pexp_q;
    assign pman      = pman_q;
    assign pzero     = pzero_q;
    assign pinf      = pinf_q;
    assign pnan      = pnan_q;

endmodule

// File: tb/tb_fma16_mul_seq.sv
// Directed self-checking bench for fma16_mul_seq. Expected values are
// hand-computed fp16 products. Build macro FMA16_MUL_EARLY_TERM_EN relaxes
// the normal-operand latency check to an upper bound.
module tb_fma16_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        psign;
    logic [6:0]  pexp;
    logic [21:0] pman;
    logic        pzero;
    logic        pinf;
    logic        pnan;

    int n_pass   = 0;
    int n_checks = 0;

    fma16_mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .psign     (psign),
        .pexp      (pexp),
        .pman      (pman),
        .pzero     (pzero),
        .pinf      (pinf),
        .pnan      (pnan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One full transaction with out_ready held high; e_lat is edges from accept to out_valid.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [21:0] e_man, input logic [6:0] e_exp,
                          input logic e_sign, input logic e_zero, input logic e_inf,
                          input logic e_nan, input int e_lat);
        int lat;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        x = a; y = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 16'hDEAD; y = 16'hBEEF;
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
`ifdef FMA16_MUL_EARLY_TERM_EN
        check({tag, ".lat_bound"}, 32'(lat <= e_lat && lat >= 1), 32'd1);
`else
        check({tag, ".lat"}, 32'(lat), 32'(e_lat));
`endif
        check({tag, ".pman"},  32'(pman),  32'(e_man));
        check({tag, ".pexp"},  32'(pexp),  32'(e_exp));
        check({tag, ".psign"}, 32'(psign), 32'(e_sign));
        check({tag, ".flags"}, {29'd0, pnan, pinf, pzero}, {29'd0, e_nan, e_inf, e_zero});
        tick();
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_ret"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.pman",      32'(pman),      32'd0);
        check("rst.pexp",      32'(pexp),      32'd0);
        check("rst.flags",     {29'd0, pnan, pinf, pzero, psign}, 32'd0);

        // 1.0 * 2.0
        run_op("one_x_two", 16'h3C00, 16'h4000, 22'h100000, 7'd16, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // 1.5 * 1.5
        run_op("1p5_sq",    16'h3E00, 16'h3E00, 22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // min subnormal * -1.0
        run_op("sub_neg",   16'h0001, 16'hBC00, 22'h000400, 7'd1,  1'b1, 1'b0, 1'b0, 1'b0, 12);
        // largest normal squared: exponent 45, mantissa 0x7FF^2
        run_op("max_sq",    16'h7BFF, 16'h7BFF, 22'h3FF001, 7'd45, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // min subnormal squared: exponent -13 (0x73 in 7 bits)
        run_op("min_sq",    16'h0001, 16'h0001, 22'h000001, 7'h73, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // inf * 0 -> NaN
        run_op("inf_zero",  16'h7C00, 16'h0000, 22'h0,      7'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1);
        // -1.0 * inf -> -inf
        run_op("neg_inf",   16'hBC00, 16'h7C00, 22'h0,      7'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1);
        // -0 * 1.0 -> -zero
        run_op("neg_zero",  16'h8000, 16'h3C00, 22'h0,      7'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1);
        // NaN * inf -> NaN wins over inf
        run_op("nan_inf",   16'h7E00, 16'hFC00, 22'h0,      7'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1);

        // Busy input ignored: offer an inf operand during CALC, product must be 1.0*2.0.
        x = 16'h3C00; y = 16'h4000; in_valid = 1'b1;
        tick();
        x = 16'h7C00; y = 16'h7C00;
        tick(); tick(); tick();
        in_valid = 1'b0;
        lat = 4;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("busy_ign.pman", 32'(pman), 32'h100000);
        check("busy_ign.pinf", 32'(pinf), 32'd0);
        tick();

        // Backpressure: hold out_ready low for 5 cycles.
        out_ready = 1'b0;
        x = 16'h3C00; y = 16'h4000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
`ifndef FMA16_MUL_EARLY_TERM_EN
        check("bp.lat", 32'(lat), 32'd12);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_pman",  32'(pman),      32'h100000);
            check("bp.hold_pexp",  32'(pexp),      32'd16);
            check("bp.in_ready",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp.release_valid", 32'(out_valid), 32'd0);
        check("bp.release_ready", 32'(in_ready),  32'd1);

        // Reset during the 5th CALC cycle.
        x = 16'h3E00; y = 16'h3E00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("midrst.no_output", 32'(seen), 32'd0);
        check("midrst.idle",      32'(in_ready), 32'd1);

        // Normal operation resumes after the aborted one.
        run_op("post_rst", 16'h3E00, 16'h4000, 22'h180000, 7'd16, 1'b0, 1'b0, 1'b0, 1'b0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
